// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the even clock divider controller.
// Holds the FSM state enum, the reset ratio and the ratio legality check.
package clk_div_pkg;

  localparam int DEF_DIV = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  // A ratio is usable when it is even and at least 2.
  function automatic logic legal_div(input logic [31:0] div);
    return (div[0] == 1'b0) && (div >= 32'd2);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter and clk_div toggle flop.
// Ports: clk, rst (async high), run, load (cnt clear), half, clk_div, pb.
module clk_div_core #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] half,
  output logic             clk_div,
  output logic             pb
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt;
  logic             at_end;

  assign at_end = (cnt == half - ONE);

  // Period boundary: last cycle of the high phase.
  assign pb = run & at_end & clk_div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      clk_div <= 1'b0;
    end else if (!run) begin
      cnt     <= '0;
      clk_div <= 1'b0;
    end else begin
      if (at_end) begin
        clk_div <= ~clk_div;
      end
      if (at_end || load) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/clk_div_sched.sv
// Run-time controller for the even clock divider: FSM, ratio slot, apply.
// Ports: clk, rst, en, cfg_valid/cfg_div/cfg_ready/cfg_err, clk_div,
//   cur_div, active, sw_done; pcnt[15:0] when CLK_DIV_SCHED_PCNT_EN is defined.
module clk_div_sched #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = clk_div_pkg::DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_div,
  output logic [CNT_W-1:0] cur_div,
  output logic             active,
  output logic             sw_done
`ifdef CLK_DIV_SCHED_PCNT_EN
  ,
  output logic [15:0]      pcnt
`endif
);

  import clk_div_pkg::*;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] pend;
  logic             pend_vld;
  logic [CNT_W-1:0] half;
  logic             run;
  logic             pb;
  logic             xfer;
  logic             cfg_ok;
  logic             apply;

  assign cfg_ready = ~pend_vld;
  assign xfer      = cfg_valid & cfg_ready;
  assign cfg_ok    = legal_div(32'(cfg_div));
  assign half      = cur_div >> 1;
  assign run       = (state != IDLE);
  assign active    = run;

  // pend_vld is only set after the transfer edge, so a PB in the
  // transfer cycle itself can never apply it.
  assign apply = pend_vld & (pb | (state == IDLE));

  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .load    (apply),
    .half    (half),
    .clk_div (clk_div),
    .pb      (pb)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN:  if (!en) state_nxt = STOP;
      // Re-enable wins over the boundary so output continues seamlessly.
      STOP: begin
        if (en) begin
          state_nxt = RUN;
        end else if (pb) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur_div  <= CNT_W'(DEF_DIV);
      pend     <= '0;
      pend_vld <= 1'b0;
      cfg_err  <= 1'b0;
      sw_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= xfer & ~cfg_ok;
      sw_done <= apply;
      if (apply) begin
        cur_div  <= pend;
        pend_vld <= 1'b0;
      end else if (xfer && cfg_ok) begin
        pend     <= cfg_div;
        pend_vld <= 1'b1;
      end
    end
  end

`ifdef CLK_DIV_SCHED_PCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (apply) begin
      pcnt <= '0;
    end else if (pb && pcnt != 16'hFFFF) begin
      pcnt <= pcnt + 16'd1;
    end
  end
`endif

endmodule
